// File: rtl/dadda_16_seq.sv
// Sequential 16x16 unsigned multiplier that reuses one 8x8 Dadda multiplier across four byte phases.
// Optional build macro DADDA_SEQ_ZERO_SKIP_EN sends zero operands straight to DONE.

module dadda_8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  localparam int NC = 17;

  function automatic int stage_target(input int s);
    return (s == 0) ? 6 : (s == 1) ? 4 : (s == 2) ? 3 : 2;
  endfunction

  // Greedy Dadda reduction: each stage adds only the adders needed so that
  // every column, including carries arriving from the column below, fits the target height.
  always_comb begin : reduce
    logic [NC-1:0][7:0] cur;
    logic [NC-1:0][7:0] nxt;
    logic [NC-1:0][3:0] ch;
    logic [NC-1:0][3:0] nh;
    logic [15:0]        row0;
    logic [15:0]        row1;
    logic               x, y, z, sum, cy;
    int                 pos, rem, tot, tgt;
    // NOTE: every variable gets a value before the loops, so no path leaves one unassigned and no latch is inferred.
    cur  = '0;
    nxt  = '0;
    ch   = '0;
    nh   = '0;
    row0 = '0;
    row1 = '0;
    x    = 1'b0;
    y    = 1'b0;
    z    = 1'b0;
    sum  = 1'b0;
    cy   = 1'b0;
    pos  = 0;
    rem  = 0;
    tot  = 0;
    tgt  = 0;

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        cur[5'(i+j)][3'(ch[5'(i+j)])] = a_i[i] & b_i[j];
        ch[5'(i+j)] = ch[5'(i+j)] + 4'd1;
      end
    end

    for (int s = 0; s < 4; s++) begin
      tgt = stage_target(s);
      nxt = '0;
      nh  = '0;
      for (int c = 0; c < NC-1; c++) begin
        pos = 0;
        for (int k = 0; k < 8; k++) begin
          rem = int'(ch[5'(c)]) - pos;
          tot = rem + int'(nh[5'(c)]);
          if (tot > tgt && rem >= 2) begin
            x = cur[5'(c)][3'(pos)];
            y = cur[5'(c)][3'(pos+1)];
            if (tot == tgt + 1 || rem == 2) begin
              sum = x ^ y;
              cy  = x & y;
              pos = pos + 2;
            end else begin
              z   = cur[5'(c)][3'(pos+2)];
              sum = x ^ y ^ z;
              cy  = (x & y) | (x & z) | (y & z);
              pos = pos + 3;
            end
            nxt[5'(c)][3'(nh[5'(c)])]     = sum;
            nh[5'(c)]                     = nh[5'(c)] + 4'd1;
            nxt[5'(c+1)][3'(nh[5'(c+1)])] = cy;
            nh[5'(c+1)]                   = nh[5'(c+1)] + 4'd1;
          end
        end
        for (int k = 0; k < 8; k++) begin
          if (pos + k < int'(ch[5'(c)])) begin
            nxt[5'(c)][3'(nh[5'(c)])] = cur[5'(c)][3'(pos+k)];
            nh[5'(c)] = nh[5'(c)] + 4'd1;
          end
        end
      end
      cur = nxt;
      ch  = nh;
    end

    for (int c = 0; c < 16; c++) begin
      row0[4'(c)] = cur[5'(c)][0];
      row1[4'(c)] = cur[5'(c)][1];
    end
    p_o = row0 + row1;
  end
endmodule

module dadda_16_seq #(
  parameter int MUL_REG = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Y,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} state_e;

  state_e      state_q;
  logic [15:0] a_q, b_q;
  logic [1:0]  phase_q;
  logic [31:0] acc_q;
  logic        in_ready_q, out_valid_q, busy_q;

  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;
  logic [15:0] add_pp;
  logic [1:0]  add_phase;
  logic [31:0] add_term, acc_d;

  function automatic logic [31:0] place_pp(input logic [15:0] pp, input logic [1:0] phase);
    case (phase)
      2'd0:    return {16'b0, pp};
      2'd3:    return {pp, 16'b0};
      default: return {8'b0, pp, 8'b0};
    endcase
  endfunction

  // Phase bit 1 picks the high byte of A, phase bit 0 the high byte of B.
  always_comb begin
    mul_a = phase_q[1] ? a_q[15:8] : a_q[7:0];
    mul_b = phase_q[0] ? b_q[15:8] : b_q[7:0];
  end

  dadda_8 u_dadda_8 (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  if (MUL_REG != 0) begin : g_mul_reg
    logic [15:0] pp_q;
    logic [1:0]  pp_phase_q;
    // NOTE: this pipeline register is reset only to keep simulation X-free; the FSM never adds it before it holds a real product.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pp_q       <= '0;
        pp_phase_q <= '0;
      end else begin
        pp_q       <= mul_p;
        pp_phase_q <= phase_q;
      end
    end
    assign add_pp    = pp_q;
    assign add_phase = pp_phase_q;
  end else begin : g_mul_comb
    assign add_pp    = mul_p;
    assign add_phase = phase_q;
  end

  assign add_term = place_pp(add_pp, add_phase);
  assign acc_d    = acc_q + add_term;

  // NOTE: non-blocking assignments make every register sample pre-edge values, so the order of statements below cannot create races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      phase_q     <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_q        <= A;
            b_q        <= B;
            acc_q      <= '0;
            phase_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef DADDA_SEQ_ZERO_SKIP_EN
            if (A == '0 || B == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else
`endif
            state_q <= MUL;
          end
        end
        MUL: begin
          phase_q <= phase_q + 2'd1;
          // With the output register the product lags one phase, so phase 0 has nothing to add yet.
          if (MUL_REG == 0 || phase_q != 2'd0) acc_q <= acc_d;
          if (phase_q == 2'd3) begin
            if (MUL_REG != 0) begin
              state_q <= DRAIN;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          acc_q       <= acc_d;
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign Y         = acc_q;
endmodule
